// File: rtl/uart_rx_bit_sampler.sv
// UART receive oversampling front end: two-flop line synchronizer, tick and bit
// counters, and a three-sample mid-bit majority vote with a one-cycle valid strobe.
module uart_rx_bit_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  enable,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  sampled_bit,
    output logic                  sample_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [PRESCALE_W-1:0] PRESCALE_RST = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] PRESCALE_MIN = PRESCALE_W'(4);

    state_e                  state_q, state_d;
    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
    logic [PRESCALE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                    s0_q, s0_d;
    logic                    s1_q, s1_d;
    logic                    sampled_bit_q, sampled_bit_d;
    logic                    sample_valid_q, sample_valid_d;

    logic                    rx_sync;
    logic [PRESCALE_W-1:0]   prescale_even;
    logic [PRESCALE_W-1:0]   half;
    logic                    majority;

    assign rx_sync       = sync2_q;
    // The period is forced even so the bit splits into two equal halves around the vote.
    assign prescale_even = {prescale[PRESCALE_W-1:1], 1'b0};
    assign half          = prescale_q >> 1;
    assign majority      = (s0_q & s1_q) | (s0_q & rx_sync) | (s1_q & rx_sync);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which is what keeps this block from inferring latches.
        state_d        = state_q;
        sync1_d        = rx_in;
        sync2_d        = sync1_q;
        prescale_d     = prescale_q;
        edge_cnt_d     = edge_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        s0_d           = s0_q;
        s1_d           = s1_q;
        sampled_bit_d  = sampled_bit_q;
        sample_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (enable) begin
                    state_d    = RUN;
                    prescale_d = (prescale_even < PRESCALE_MIN) ? PRESCALE_MIN : prescale_even;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Dropping enable abandons any vote in progress.
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else begin
                    if (edge_cnt_q == prescale_q - PRESCALE_W'(1)) begin
                        edge_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
                    end else begin
                        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
                    end
                    if (edge_cnt_q == half - PRESCALE_W'(2)) s0_d = rx_sync;
                    if (edge_cnt_q == half - PRESCALE_W'(1)) s1_d = rx_sync;
                    if (edge_cnt_q == half) begin
                        sampled_bit_d  = majority;
                        sample_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            prescale_q     <= PRESCALE_RST;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            s0_q           <= 1'b1;
            s1_q           <= 1'b1;
            sampled_bit_q  <= 1'b1;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            prescale_q     <= prescale_d;
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            s0_q           <= s0_d;
            s1_q           <= s1_d;
            sampled_bit_q  <= sampled_bit_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign edge_cnt     = edge_cnt_q;
    assign bit_cnt      = bit_cnt_q;
    assign sampled_bit  = sampled_bit_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Directed bench for uart_rx_bit_sampler: reset, framing, majority vote, prescale
// latching, enable drop/re-enable and asynchronous mid-frame reset.
module tb_uart_rx_bit_sampler;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       enable;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit;
    logic       sample_valid;

    int          tests;
    int          failures;
    string       tname;
    logic [255:0] rx_pat;

    uart_rx_bit_sampler #(
        .PRESCALE_W(6),
        .BIT_CNT_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .enable      (enable),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .sampled_bit (sampled_bit),
        .sample_valid(sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s/%s: observed %0d expected %0d", tname, tag, obs, exp);
        end
    endtask

    // Drive the line for the current cycle, then move to 1 time unit after the next edge.
    task automatic cyc(input logic rx);
        rx_in = rx;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_edge_cnt", edge_cnt, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        check("rst_sampled_bit", sampled_bit, 1);
        check("rst_sample_valid", sample_valid, 0);
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        for (int i = 0; i < n; i++) begin
            cyc(1'b1);
            check("idle_edge_cnt", edge_cnt, 0);
            check("idle_bit_cnt", bit_cnt, 0);
            check("idle_sample_valid", sample_valid, 0);
        end
    endtask

    // Steps n cycles driving rx_pat; cycle i must show tick (i-1)%period, the strobe
    // on tick period/2+1, and the hand-computed bit exp_bits[bit] on each strobe.
    task automatic run(input int n, input int period, input int start_bit,
                       input logic [15:0] exp_bits, input int exp_strobes);
        int e;
        int b;
        int strobes;
        strobes = 0;
        for (int i = 1; i <= n; i++) begin
            cyc(rx_pat[i-1]);
            e = (i - 1) % period;
            b = (start_bit + (i - 1) / period) % 16;
            check("edge_cnt", edge_cnt, e);
            check("bit_cnt", bit_cnt, b);
            check("sample_valid", sample_valid, (e == period / 2 + 1) ? 1 : 0);
            if (e == period / 2 + 1)
                check("sampled_bit", sampled_bit, exp_bits[(i - 1) / period]);
            if (sample_valid === 1'b1) strobes++;
        end
        check("strobe_count", strobes, exp_strobes);
    endtask

    initial begin
        logic [9:0] t4_bits;
        tests    = 0;
        failures = 0;

        tname    = "T1_reset";
        rst      = 1'b0;
        enable   = 1'b1;
        prescale = 6'd8;
        rx_in    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(i[0]);
            check_reset_outputs();
        end
        enable = 1'b0;
        rst    = 1'b1;
        idle(3);

        tname    = "T2_basic";
        prescale = 6'd8;
        for (int k = 0; k < 256; k++) rx_pat[k] = (k >= 8);
        enable = 1'b1;
        run(16, 8, 0, 16'b10, 2);
        idle(2);

        tname    = "T3_glitch";
        prescale = 6'd16;
        rx_pat   = '0;
        rx_pat[6]  = 1'b1;
        rx_pat[21] = 1'b1;
        rx_pat[22] = 1'b1;
        enable = 1'b1;
        run(32, 16, 0, 16'b10, 2);
        idle(2);

        tname    = "T4_wrap";
        prescale = 6'd16;
        t4_bits  = 10'b1100101001;
        for (int k = 0; k < 256; k++) rx_pat[k] = (k < 160) ? t4_bits[k / 16] : 1'b1;
        enable = 1'b1;
        run(160, 16, 0, {6'b0, t4_bits}, 10);
        idle(2);

        tname    = "T5_odd_prescale";
        prescale = 6'd9;
        rx_pat   = '0;
        enable   = 1'b1;
        run(24, 8, 0, 16'b000, 3);
        idle(2);

        tname    = "T5_small_prescale";
        prescale = 6'd2;
        rx_pat   = '0;
        rx_pat[0] = 1'b1;
        rx_pat[8] = 1'b1;
        rx_pat[9] = 1'b1;
        enable = 1'b1;
        run(12, 4, 0, 16'b101, 3);
        idle(2);

        tname    = "T5_midframe_prescale";
        prescale = 6'd16;
        rx_pat   = '0;
        enable   = 1'b1;
        run(16, 16, 0, 16'b0, 1);
        prescale = 6'd32;
        run(16, 16, 1, 16'b0, 1);
        idle(2);
        tname  = "T5_relatch";
        rx_pat = '1;
        enable = 1'b1;
        run(40, 32, 0, 16'b1, 1);
        idle(2);

        tname    = "T6_enable_drop";
        prescale = 6'd8;
        rx_pat   = '0;
        enable   = 1'b1;
        run(28, 8, 0, 16'b000, 3);
        enable = 1'b0;
        cyc(1'b0);
        check("drop_edge_cnt", edge_cnt, 0);
        check("drop_bit_cnt", bit_cnt, 0);
        check("drop_sample_valid", sample_valid, 0);
        tname  = "T6_reenable";
        rx_pat = '1;
        enable = 1'b1;
        run(8, 8, 0, 16'b1, 1);
        rx_pat = '0;
        run(6, 8, 1, 16'b0, 1);
        check("pre_reset_sampled_bit", sampled_bit, 0);

        tname = "T7_async_reset";
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        cyc(1'b0);
        check_reset_outputs();
        enable = 1'b0;
        rst    = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
